scan_sel_ctrl: RTL
==================

// Module: scan_sel_ctrl
// PURPOSE
//  Time-multiplexed scan scheduler for an 8-way active-low select bus, e.g. the digit enables of a
//  multiplexed LED/7-segment array. It steps round-robin through enabled outputs, holds each
//  one for a programmable on-time and inserts an all-inactive blanking gap between outputs
//  (anti-ghosting). Output polarity is selectable at run time. Sits between the
//  display/register front end and the pad drivers.
// PARAMETERS
//  PRESCALE     1000  clock cycles per scan tick (>=1)
//  ON_TICKS     4     ticks each selected output is held active (>=1)
//  BLANK_TICKS  1     ticks of all-inactive gap before each new selection (>=1)
// PORTS
//  i_clk    in   1  clock; single clock domain
//  i_rst_n  in   1  asynchronous, active-low reset
//  i_en     in   1  scan enable; 0 forces IDLE
//  i_mask   in   8  per-output enable; bit k=1 -> output k takes part in the scan
//  i_opt    in   1  polarity; 0 = active-low one-hot (inactive 8'hff), 1 = active-high (inactive 8'h00)
//  o_sel    out  3  index of the current or last selected output
//  o_y      out  8  registered select bus; active bit = o_sel while in ON, else all inactive
//  o_blank  out  1  1 when o_y is all inactive (IDLE or BLANK)
//  o_frame  out  1  1-cycle pulse when a selection advance wraps (new index <= old index)
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=IDLE, prescaler=0, tick counter=0, o_sel=0, o_y=8'hff,
//   o_blank=1, o_frame=0. First clock after release: o_y = inactive value for i_opt.
//  Prescaler: free-runs 0..PRESCALE-1 while state!=IDLE; tick = (cnt==PRESCALE-1). It clears on
//   IDLE entry. PRESCALE=1 gives a tick every cycle.
//  FSM:
//   IDLE : o_y inactive. If i_en=1 and i_mask!=0 -> BLANK on the next edge, with counters cleared.
//   BLANK: o_y inactive. After BLANK_TICKS ticks -> ON. On that same edge, o_sel <= next enabled
//          index after o_sel (search o_sel+1..7, then 0..o_sel, mod 8). o_frame=1 that cycle if
//          new index <= old index.
//   ON   : o_y = decoded o_sel. After ON_TICKS ticks -> BLANK.
//   Any state: i_en=0 or i_mask==0 -> IDLE next edge. o_sel is kept, so the scan resumes after it.
//  Mask change in ON: if i_mask[o_sel] drops to 0, go to BLANK next edge. This abandons the
//   on-time and clears the tick count. Mask changes in BLANK take effect at the advance.
//  Single enabled output: it is reselected every advance, the BLANK gap is still inserted, and
//   o_frame pulses every advance.
//  Priority on one edge: IDLE forcing > masked-out abort > tick-driven transition.
//  Decode: active pattern = ~(8'b1 << o_sel), inverted when i_opt=1. o_y, o_blank and o_frame are
//   registered; o_y lags the state/o_sel update by 0 cycles, i.e. all update on the same edge.
//   An i_opt change is reflected on o_y on the next edge in every state.
//  Widths: tick counter is sized for max(ON_TICKS,BLANK_TICKS); prescaler uses $clog2(PRESCALE)
//   bits, minimum 1. No counter wraps except at its terminal value.
//  Reset mid-scan: immediate return to reset values, with no partial pulse on o_frame.
// STRUCTURE
//  scan_defs.vh: state encodings (ST_IDLE/ST_BLANK/ST_ON), NSEL=8, SEL_W=3, INACT_LO=8'hff.
//  Sub-module rr_next_sel: combinational, (cur[2:0], mask[7:0]) -> (nxt[2:0], wrap).
//   Round-robin search starting after cur; it is unit-tested on its own.
//  Top holds the prescaler, tick counter, FSM and output registers.
// TESTING (PRESCALE=2, ON_TICKS=3, BLANK_TICKS=1 unless stated)
//  1 Reset: hold i_rst_n=0 with i_en=1 and i_mask=8'hff -> o_y=8'hff, o_sel=0, o_blank=1,
//    o_frame=0. Assert and release asynchronously, mid-cycle.
//  2 Full scan, i_opt=0, mask=8'hff: after release o_sel goes 1,2,..7,0. Each ON lasts 6 cycles
//    with o_y=~(1<<o_sel). Each BLANK lasts 2 cycles at 8'hff. o_frame pulses once on 7->0.
//  3 Sparse mask 8'b1000_0101: sequence 2,7,0,2,...; o_frame at 7->0 only. i_opt=1 ->
//    o_y=8'h04 while sel=2 and 8'h00 in BLANK.
//  4 Single output, mask=8'h10: o_sel stays 4 with ON/BLANK alternating 6/2 cycles, and o_frame
//    pulses every advance.
//  5 Drop i_mask[o_sel] mid-ON -> BLANK next edge, then advance to the next enabled index.
//    Set mask=0 -> IDLE and o_y inactive.
//  6 i_en=0 mid-ON with o_sel=5 -> IDLE next edge. Re-enable -> BLANK, then o_sel=6.
//    Also check PRESCALE=1, where ON lasts exactly 3 cycles.

Source files
------------

// File: rtl/scan_sel_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scan_sel_ctrl_pkg : shared constants and select-bus decode for the scan block
// Rev 1.0
// ---------------------------------------------------------------------------
package scan_sel_ctrl_pkg;

  localparam int NSEL  = 8;
  localparam int SEL_W = 3;
  localparam logic [NSEL-1:0] INACT_LO = 8'hff;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_ON    = 2'd2;

  // Active-low one-hot pattern, or all-inactive; the whole bus flips for active-high pads.
  function automatic logic [NSEL-1:0] decode_sel(input logic on, input logic [SEL_W-1:0] sel,
                                                 input logic opt);
    logic [NSEL-1:0] pat;
    pat = on ? ~(NSEL'(1) << sel) : INACT_LO;
    return opt ? ~pat : pat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_next_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_next_sel : combinational round-robin search for the next enabled output
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_next_sel
  import scan_sel_ctrl_pkg::*;
(
  input  logic [SEL_W-1:0] cur,
  input  logic [NSEL-1:0]  mask,
  output logic [SEL_W-1:0] nxt,
  output logic             wrap
);

  logic             found;
  logic [SEL_W-1:0] idx;

  // Offsets 1..NSEL so cur itself is the last candidate (single-output case).
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = cur;
    for (int i = 1; i <= NSEL; i++) begin
      idx = cur + SEL_W'(i);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    wrap = found && (nxt <= cur);
  end

endmodule
`default_nettype wire

// File: rtl/scan_sel_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scan_sel_ctrl : round-robin scan scheduler with blanking for an 8-way select bus
// Rev 1.0
// ---------------------------------------------------------------------------
module scan_sel_ctrl
  import scan_sel_ctrl_pkg::*;
#(
  parameter int PRESCALE    = 1000,
  parameter int ON_TICKS    = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [NSEL-1:0]  i_mask,
  input  logic             i_opt,
  output logic [SEL_W-1:0] o_sel,
  output logic [NSEL-1:0]  o_y,
  output logic             o_blank,
  output logic             o_frame
);

  localparam int TICK_MAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(PRESCALE - 1);
  localparam logic [TICK_W-1:0] ON_LAST    = TICK_W'(ON_TICKS - 1);
  localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'(BLANK_TICKS - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [PRE_W-1:0] pre_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [SEL_W-1:0] sel_nxt;
  logic [SEL_W-1:0] rr_nxt;
  logic             rr_wrap;
  logic             tick;
  logic             tick_done;
  logic             run;
  logic             adv;

  rr_next_sel u_rr (
    .cur  (o_sel),
    .mask (i_mask),
    .nxt  (rr_nxt),
    .wrap (rr_wrap)
  );

  assign tick      = (pre_cnt == PRE_LAST);
  assign run       = i_en && (i_mask != '0);
  assign tick_done = tick && (tick_cnt == ((state == ST_ON) ? ON_LAST : BLANK_LAST));

  // Idle forcing outranks the masked-out abort, which outranks tick-driven moves.
  always_comb begin
    state_nxt = state;
    sel_nxt   = o_sel;
    adv       = 1'b0;
    if (!run) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_BLANK;
        ST_BLANK: begin
          if (tick_done) begin
            state_nxt = ST_ON;
            sel_nxt   = rr_nxt;
            adv       = 1'b1;
          end
        end
        ST_ON: begin
          if (!i_mask[o_sel] || tick_done) state_nxt = ST_BLANK;
        end
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      pre_cnt  <= '0;
      tick_cnt <= '0;
      o_sel    <= '0;
      o_y      <= INACT_LO;
      o_blank  <= 1'b1;
      o_frame  <= 1'b0;
    end else begin
      state <= state_nxt;
      o_sel <= sel_nxt;

      if (state == ST_IDLE || state_nxt == ST_IDLE || tick) pre_cnt <= '0;
      else                                                  pre_cnt <= pre_cnt + PRE_W'(1);

      // Every state change, including an abort, restarts the tick count.
      if (state_nxt != state || state == ST_IDLE) tick_cnt <= '0;
      else if (tick)                              tick_cnt <= tick_cnt + TICK_W'(1);

      o_y     <= decode_sel(state_nxt == ST_ON, sel_nxt, i_opt);
      o_blank <= (state_nxt != ST_ON);
      o_frame <= adv && rr_wrap;
    end
  end

endmodule
`default_nettype wire
